spi_master_arbiter: RTL
=======================

// Module: spi_master_arbiter
// PURPOSE
//  Shares one spi_master between N_REQ requesters. Round-robin arbitration; drives
//  start/din/mode/reset of the master, tracks the transaction through SS, and
//  returns a per-requester done or err pulse. Resets the master on a CPOL change
//  so SCLK idles at the new level. Sits between client logic and spi_master.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  TIMEOUT  64  max cycles from start pulse to SS rising before abort (>=24)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  reset      in   1        asynchronous, active-high reset
//  req        in   N_REQ    request per requester; held high until done/err
//  req_din    in   8*N_REQ  byte per requester, [8i+7:8i] = requester i
//  req_mode   in   2*N_REQ  SPI mode per requester, [2i+1:2i]; bit1 = CPOL
//  gnt        out  N_REQ    one-hot grant, high for the whole transaction
//  done       out  N_REQ    1-cycle pulse to owner on normal completion
//  err        out  N_REQ    1-cycle pulse to owner on timeout abort
//  busy       out  1        high in every state except IDLE
//  m_start    out  1        to master start; 1-cycle pulse
//  m_din      out  8        to master din; registered at grant, stable until next grant
//  m_mode     out  2        to master mode; registered at grant, stable until next grant
//  m_reset    out  1        to master reset; 1-cycle pulse
//  m_ss       in   1        from master SS; low = transfer in progress
// BEHAVIOUR
//  Reset: gnt=0, done=0, err=0, busy=0, m_start=0, m_reset=0, m_din=0, m_mode=0,
//   rr_ptr=N_REQ-1, cpol_valid=0, state=IDLE. Reset mid-transfer clears all at once.
//  FSM (one state per cycle unless noted):
//   IDLE: if |req, pick winner: first set bit searching from rr_ptr+1 upward, wrap
//    modulo N_REQ. Register gnt, m_din, m_mode; rr_ptr<=winner. Go PREP if
//    !cpol_valid or winner CPOL != last_cpol; else go START.
//   PREP: m_reset=1 for this cycle only; last_cpol<=m_mode[1]; cpol_valid<=1.
//    Go RECOV.
//   RECOV: 1 cycle, all strobes low, for master S5->S0. Go START.
//   START: m_start=1 for this cycle only; clear timer. Go WAIT_LO.
//   WAIT_LO: wait m_ss==0. Go WAIT_HI.
//   WAIT_HI: wait m_ss==1. Go DONE.
//   DONE: done[winner]=1 for 1 cycle; gnt cleared on the next edge; go IDLE.
//  Timer counts every cycle in WAIT_LO/WAIT_HI. On reaching TIMEOUT: go ABORT.
//  ABORT: m_reset=1 for 1 cycle, err[winner]=1, cpol_valid<=0; gnt cleared on next
//   edge; go IDLE. The next grant always passes through PREP.
//  Nominal: START to DONE = 20 cycles (S1, 8x S2/S3, S4, SS sampled high);
//   IDLE to IDLE = 22 cycles without PREP, 24 with PREP.
//  Requests arriving in the DONE or ABORT cycle are arbitrated in the following
//   IDLE cycle. Grant never changes mid-transfer.
//  req[i] dropping while granted: ignored; transfer completes and done/err pulses.
//  req_din/req_mode changes after grant: ignored; registered copies are used.
//  At most one bit of gnt|done|err is set at any time; done and err are never both set.
// TESTING
//  1 Post-reset req=4'b0001, din0=8'hA5, mode0=0 -> gnt=0001; m_reset pulse (PREP),
//    m_start 2 cycles later, m_din=A5, done[0] 20 cycles after start.
//  2 Repeat with mode0=1 (same CPOL) -> no m_reset; m_start 1 cycle after grant.
//  3 req=4'b1111 held -> grant order 0,1,2,3,0; one IDLE cycle between transfers.
//  4 req0 mode=0, then req1 mode=2 -> m_reset before second start; slave echo byte
//    checked in mode 2.
//  5 m_ss forced 1 (master disconnected) -> err[i] after TIMEOUT cycles; m_reset pulse;
//    next grant goes through PREP.
//  6 Assert reset during WAIT_HI -> gnt/busy/m_start/m_reset=0 immediately;
//    after release, first grant goes through PREP.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ requesters.
// Tracks each transfer through SS and returns a per-requester done/err pulse.
module spi_master_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_din,
  input  logic [2*N_REQ-1:0] req_mode,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic               m_start,
  output logic [7:0]         m_din,
  output logic [1:0]         m_mode,
  output logic               m_reset,
  input  logic               m_ss
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, PREP, RECOV, START, WAIT_LO, WAIT_HI, DONE, ABORT
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic          cpol_valid;
  logic          last_cpol;
  logic [TW-1:0] timer;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic [N_REQ-1:0] win_onehot;
  logic [7:0]       win_din;
  logic [1:0]       win_mode;

  // Search starts just above the last winner and wraps modulo N_REQ.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    win_din    = '0;
    win_mode   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PW'((32'(rr_ptr) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found        = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (win_onehot[j]) begin
        win_din  = req_din[8*j +: 8];
        win_mode = req_mode[2*j +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= PW'(N_REQ - 1);
      cpol_valid <= 1'b0;
      last_cpol  <= 1'b0;
      timer      <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      busy       <= 1'b0;
      m_start    <= 1'b0;
      m_reset    <= 1'b0;
      m_din      <= '0;
      m_mode     <= '0;
    end else begin
      m_start <= 1'b0;
      m_reset <= 1'b0;
      done    <= '0;
      err     <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt    <= win_onehot;
            m_din  <= win_din;
            m_mode <= win_mode;
            rr_ptr <= win_idx;
            busy   <= 1'b1;
            if (!cpol_valid || (win_mode[1] != last_cpol)) begin
              state   <= PREP;
              m_reset <= 1'b1;
            end else begin
              state   <= START;
              m_start <= 1'b1;
            end
          end
        end
        PREP: begin
          last_cpol  <= m_mode[1];
          cpol_valid <= 1'b1;
          state      <= RECOV;
        end
        RECOV: begin
          state   <= START;
          m_start <= 1'b1;
        end
        START: begin
          timer <= '0;
          state <= WAIT_LO;
        end
        // Timer runs across both wait states; the abort wins when it reaches TIMEOUT.
        WAIT_LO, WAIT_HI: begin
          timer <= timer + 1'b1;
          if (timer == TW'(TIMEOUT - 1)) begin
            state   <= ABORT;
            m_reset <= 1'b1;
            err     <= gnt;
          end else if (state == WAIT_LO && !m_ss) begin
            state <= WAIT_HI;
          end else if (state == WAIT_HI && m_ss) begin
            state <= DONE;
            done  <= gnt;
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ABORT: begin
          cpol_valid <= 1'b0;
          gnt        <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
